// File: rtl/op_issuer_pkg.sv
// -----------------------------------------------------------------------------
// op_issuer_pkg
// Shared definitions for the matrix-controller operation issuers.
//   - opcode constants carried in operation[3:0]
//   - 4-bit chunk positions inside the 16 used bits of an operation word
//   - issuer FSM state encoding
//   - page-field helpers (bit3 selects the WRF, bits[1:0] the page index)
// No ports (package).
// -----------------------------------------------------------------------------
package op_issuer_pkg;

  localparam logic [3:0] OP_IDLE   = 4'd0;
  localparam logic [3:0] OP_MATMUL = 4'd1;
  localparam logic [3:0] OP_LOAD   = 4'd2;

  localparam int CH_W    = 4;
  localparam int CH0_LSB = 0;
  localparam int CH1_LSB = 4;
  localparam int CH2_LSB = 8;
  localparam int CH3_LSB = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_MM_RUN = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // Page field: bit3 high means the page lives in the WRF.
  function automatic logic page_is_wrf(input logic [3:0] field);
    return field[3];
  endfunction

  // Page field: bits[1:0] index the page inside the selected memory.
  function automatic logic [1:0] page_index(input logic [3:0] field);
    return field[1:0];
  endfunction

endpackage

// File: rtl/op_issuer_pack.sv
// -----------------------------------------------------------------------------
// op_pack
// Combinational encoder: places an opcode and three 4-bit chunks into a 32-bit
// controller operation word. Bits [31:16] are always zero.
// Ports:
//   i_opcode [3:0]  -> word[3:0]
//   i_ch1    [3:0]  -> word[7:4]
//   i_ch2    [3:0]  -> word[11:8]
//   i_ch3    [3:0]  -> word[15:12]
//   o_word   [31:0] packed operation word
// -----------------------------------------------------------------------------
module op_pack
  import op_issuer_pkg::*;
(
  input  logic [3:0]  i_opcode,
  input  logic [3:0]  i_ch1,
  input  logic [3:0]  i_ch2,
  input  logic [3:0]  i_ch3,
  output logic [31:0] o_word
);

  // Pack opcode and chunks into their fixed positions
  always_comb begin
    o_word                     = 32'd0;
    o_word[CH0_LSB +: CH_W]    = i_opcode;
    o_word[CH1_LSB +: CH_W]    = i_ch1;
    o_word[CH2_LSB +: CH_W]    = i_ch2;
    o_word[CH3_LSB +: CH_W]    = i_ch3;
  end

endmodule

// File: rtl/op_issuer.sv
// -----------------------------------------------------------------------------
// op_issuer
// Host-side initiator for the matrix controller operation/in_data interface.
// Turns LOAD and MATMUL commands into cycle-exact, registered operation words.
// Every command is followed by one GAP cycle plus the IDLE accept cycle, so the
// controller always sees at least two zero words before the next opcode edge.
// Ports:
//   clk                 clock, rising edge
//   reset               asynchronous active-low reset
//   enable              low freezes all state/outputs and blocks handshakes
//   cmd_valid/cmd_ready command handshake (ready only in IDLE)
//   cmd_type            0 = LOAD, 1 = MATMUL
//   cmd_a/cmd_b/cmd_c   LOAD: page/mask/-- ; MATMUL: x/w/y pages
//   cmd_len [LEN_W]     LOAD word count
//   data_valid/ready    load word handshake (ready only in LOAD)
//   data_in [32]        load word
//   operation [32]      registered controller operation word
//   in_data [32]        registered controller data word
//   busy                state != IDLE
//   done                one-cycle pulse after a command's last word
// -----------------------------------------------------------------------------
module op_issuer
  import op_issuer_pkg::*;
#(
  parameter int MM_SHIFT = 64,
  parameter int MM_DRAIN = 16,
  parameter int LEN_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_type,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [3:0]       cmd_c,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [31:0]      data_in,
  output logic [31:0]      operation,
  output logic [31:0]      in_data,
  output logic             busy,
  output logic             done
);

  localparam int MM_TOTAL = MM_SHIFT + MM_DRAIN;
  localparam int MM_CW    = $clog2(MM_TOTAL);
  localparam int CNT_W    = (LEN_W > MM_CW) ? LEN_W : MM_CW;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MM_CNT_INIT = CNT_W'(MM_TOTAL - 1);
  localparam logic [LEN_W-1:0] LEN_ZERO    = {LEN_W{1'b0}};

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [3:0]       r_c;
  logic [3:0]       w_a_nxt;
  logic [3:0]       w_b_nxt;
  logic [3:0]       w_c_nxt;
  logic [3:0]       w_opcode;
  logic [3:0]       w_ch1;
  logic [3:0]       w_ch2;
  logic [3:0]       w_ch3;
  logic [31:0]      w_op_word;
  logic [31:0]      r_operation;
  logic [31:0]      r_in_data;
  logic [31:0]      w_in_data_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_cmd_ready;
  logic             r_data_ready;
  logic             r_busy;
  logic             w_cmd_fire;
  logic             w_data_fire;

  // Ready flags are registered; gating with enable makes a frozen issuer
  // refuse handshakes in the same cycle enable drops.
  assign cmd_ready   = r_cmd_ready & enable;
  assign data_ready  = r_data_ready & enable;
  assign w_cmd_fire  = cmd_valid & cmd_ready;
  assign w_data_fire = data_valid & data_ready;

  assign operation = r_operation;
  assign in_data   = r_in_data;
  assign busy      = r_busy;
  assign done      = r_done & enable;

  op_pack u_op_pack (
    .i_opcode (w_opcode),
    .i_ch1    (w_ch1),
    .i_ch2    (w_ch2),
    .i_ch3    (w_ch3),
    .o_word   (w_op_word)
  );

  // Next-state, counter and next operation word
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_c_nxt       = r_c;
    w_opcode      = OP_IDLE;
    w_ch1         = 4'd0;
    w_ch2         = 4'd0;
    w_ch3         = 4'd0;
    w_in_data_nxt = r_in_data;
    w_done_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          w_a_nxt = cmd_a;
          w_b_nxt = cmd_b;
          if (cmd_type) begin
            // MATMUL word goes out on the accept edge, so the counter covers
            // the remaining MM_TOTAL-1 words plus the exit cycle.
            w_c_nxt     = cmd_c;
            w_state_nxt = ST_MM_RUN;
            w_cnt_nxt   = MM_CNT_INIT;
            w_opcode    = OP_MATMUL;
            w_ch1       = cmd_a;
            w_ch2       = cmd_b;
            w_ch3       = cmd_c;
          end else if (cmd_len == LEN_ZERO) begin
            w_c_nxt     = 4'd0;
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = CNT_ZERO;
            w_done_nxt  = 1'b1;
          end else begin
            w_c_nxt     = 4'd0;
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = CNT_W'(cmd_len);
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = ST_GAP;
          w_done_nxt  = 1'b1;
        end else if (w_data_fire) begin
          w_opcode      = OP_LOAD;
          w_ch1         = r_a;
          w_ch2         = r_b;
          w_in_data_nxt = data_in;
          w_cnt_nxt     = r_cnt - CNT_ONE;
        end else begin
          // Bubble: operation 0, in_data keeps the last written word
          w_opcode = OP_IDLE;
        end
      end

      ST_MM_RUN: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = ST_GAP;
          w_done_nxt  = 1'b1;
        end else begin
          w_opcode  = OP_MATMUL;
          w_ch1     = r_a;
          w_ch2     = r_b;
          w_ch3     = r_c;
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, latched fields and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= CNT_ZERO;
      r_a          <= 4'd0;
      r_b          <= 4'd0;
      r_c          <= 4'd0;
      r_operation  <= 32'd0;
      r_in_data    <= 32'd0;
      r_done       <= 1'b0;
      r_cmd_ready  <= 1'b0;
      r_data_ready <= 1'b0;
      r_busy       <= 1'b0;
    end else if (enable) begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_c          <= w_c_nxt;
      r_operation  <= w_op_word;
      r_in_data    <= w_in_data_nxt;
      r_done       <= w_done_nxt;
      r_cmd_ready  <= (w_state_nxt == ST_IDLE);
      r_data_ready <= (w_state_nxt == ST_LOAD) && (w_cnt_nxt != CNT_ZERO);
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_op_issuer
// Self-checking bench for op_issuer. Expected words come from the command
// rules (field packing, 80-cycle matmul runs, one word per data handshake).
// -----------------------------------------------------------------------------
module tb_op_issuer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_type;
  logic [3:0]  cmd_a;
  logic [3:0]  cmd_b;
  logic [3:0]  cmd_c;
  logic [7:0]  cmd_len;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data_in;
  logic [31:0] operation;
  logic [31:0] in_data;
  logic        busy;
  logic        done;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_in;

  localparam int MM_RUN_LEN = 80;

  op_issuer #(.MM_SHIFT(64), .MM_DRAIN(16), .LEN_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_type   (cmd_type),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_c      (cmd_c),
    .cmd_len    (cmd_len),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_in    (data_in),
    .operation  (operation),
    .in_data    (in_data),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; cmd_valid = 1'b1; cmd_type = 1'b1;
    cmd_a = 4'd0; cmd_b = 4'd0; cmd_c = 4'd0; cmd_len = 8'd0;
    data_valid = 1'b0; data_in = 32'd0; exp_in = 32'd0;
    repeat (3) step();
    n_cmp++;
    if (operation !== 32'd0 || in_data !== 32'd0) begin
      n_err++; $display("FAIL rst_data: got op=%h in=%h expected 0/0", operation, in_data);
    end
    n_cmp++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || data_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_flags: got rdy=%b busy=%b done=%b drdy=%b expected 0", cmd_ready, busy, done, data_ready);
    end
    cmd_valid = 1'b0;
    reset = 1'b1;
    step();
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || operation !== 32'd0) begin
      n_err++; $display("FAIL rst_release: got rdy=%b busy=%b op=%h expected 1/0/0", cmd_ready, busy, operation);
    end
  endtask

  // mode 0: contiguous data, 1: valid pattern 1,0,1,..., 2: random valid
  task automatic run_load(input logic [3:0] pg, input logic [3:0] mk, input logic [7:0] len,
                          input int mode, input logic [31:0] base, input bit rnd);
    logic [31:0] w;
    logic [31:0] d;
    int          sent;
    int          writes;
    bit          v;
    w = {16'h0000, mk, pg, 4'h2};
    sent = 0; writes = 0;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL ld_cmd_ready: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_type = 1'b0; cmd_a = pg; cmd_b = mk;
    cmd_c = 4'($urandom); cmd_len = len;
    step();
    cmd_valid = 1'b0;
    n_cmp++;
    if (operation !== 32'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL ld_accept: got op=%h busy=%b expected 0/1", operation, busy);
    end
    for (int cyc = 0; (cyc < 200) && (sent < int'(len)); cyc++) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = ((cyc % 2) == 0);
      else v = 1'($urandom_range(0, 1));
      d = rnd ? $urandom : (base + 32'(sent));
      n_cmp++;
      if (data_ready !== 1'b1) begin
        n_err++; $display("FAIL ld_data_ready: got %b expected 1", data_ready);
      end
      data_valid = v; data_in = d;
      step();
      data_valid = 1'b0;
      n_cmp++;
      if (v) begin
        sent++;
        exp_in = d;
        if (operation !== w || in_data !== exp_in) begin
          n_err++; $display("FAIL ld_word: got op=%h in=%h expected %h/%h", operation, in_data, w, exp_in);
        end else begin
          writes++;
        end
      end else begin
        if (operation !== 32'd0 || in_data !== exp_in) begin
          n_err++; $display("FAIL ld_bubble: got op=%h in=%h expected 0/%h", operation, in_data, exp_in);
        end
      end
    end
    n_cmp++;
    if (writes !== int'(len) || data_ready !== 1'b0) begin
      n_err++; $display("FAIL ld_writes: got writes=%0d drdy=%b expected %0d/0", writes, data_ready, len);
    end
    step();
    n_cmp++;
    if (operation !== 32'd0 || done !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL ld_gap: got op=%h done=%b busy=%b expected 0/1/1", operation, done, busy);
    end
    step();
    n_cmp++;
    if (operation !== 32'd0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || in_data !== exp_in) begin
      n_err++; $display("FAIL ld_idle: got op=%h done=%b busy=%b rdy=%b in=%h expected 0/0/0/1/%h",
                        operation, done, busy, cmd_ready, in_data, exp_in);
    end
  endtask

  task automatic test_load_basic();
    run_load(4'h9, 4'h3, 8'd3, 0, 32'h0000000A, 1'b0);
  endtask

  task automatic test_load_gapped();
    run_load(4'h5, 4'hC, 8'd2, 1, 32'h00000000, 1'b1);
  endtask

  task automatic test_load_zero();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL lz_ready: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_type = 1'b0; cmd_a = 4'h2; cmd_b = 4'hF; cmd_len = 8'd0;
    step();
    cmd_valid = 1'b0;
    n_cmp++;
    if (operation !== 32'd0 || done !== 1'b1 || busy !== 1'b1 || data_ready !== 1'b0) begin
      n_err++; $display("FAIL lz_gap: got op=%h done=%b busy=%b drdy=%b expected 0/1/1/0", operation, done, busy, data_ready);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || in_data !== exp_in) begin
      n_err++; $display("FAIL lz_idle: got done=%b busy=%b rdy=%b in=%h expected 0/0/1/%h", done, busy, cmd_ready, in_data, exp_in);
    end
  endtask

  task automatic test_load_random();
    for (int k = 0; k < 4; k++) begin
      run_load(4'($urandom), 4'($urandom), 8'($urandom_range(1, 6)), 2, 32'd0, 1'b1);
    end
  endtask

  task automatic run_matmul(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [31:0] w;
    int          ones;
    w = {16'h0000, c, b, a, 4'h1};
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL mm_ready: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_type = 1'b1; cmd_a = a; cmd_b = b; cmd_c = c; cmd_len = 8'($urandom);
    step();
    cmd_valid = 1'b0;
    ones = 0;
    for (int i = 0; i < 300; i++) begin
      if (operation !== w) break;
      ones++;
      step();
    end
    n_cmp++;
    if (ones !== MM_RUN_LEN) begin
      n_err++; $display("FAIL mm_len: got %0d cycles of %h expected %0d", ones, w, MM_RUN_LEN);
    end
    n_cmp++;
    if (operation !== 32'd0 || done !== 1'b1) begin
      n_err++; $display("FAIL mm_gap: got op=%h done=%b expected 0/1", operation, done);
    end
    step();
    n_cmp++;
    if (operation !== 32'd0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL mm_idle: got op=%h done=%b busy=%b rdy=%b expected 0/0/0/1", operation, done, busy, cmd_ready);
    end
  endtask

  task automatic test_matmul();
    logic [31:0] fixed_word;
    run_matmul(4'h0, 4'h1, 4'h2);
    fixed_word = 32'h00002101;
    // Re-issue the reference command and confirm its first word literally
    cmd_valid = 1'b1; cmd_type = 1'b1; cmd_a = 4'h0; cmd_b = 4'h1; cmd_c = 4'h2;
    step();
    cmd_valid = 1'b0;
    n_cmp++;
    if (operation !== fixed_word) begin
      n_err++; $display("FAIL mm_word: got %h expected %h", operation, fixed_word);
    end
    for (int i = 0; (i < 200) && (busy === 1'b1); i++) step();
    for (int k = 0; k < 2; k++) begin
      run_matmul(4'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  a1, b1, c1, a2, b2, c2;
    logic [31:0] w1, w2;
    int          ones1, zeros, ones2;
    a1 = 4'($urandom); b1 = 4'($urandom); c1 = 4'($urandom);
    a2 = ~a1; b2 = 4'($urandom); c2 = 4'($urandom);
    w1 = {16'h0000, c1, b1, a1, 4'h1};
    w2 = {16'h0000, c2, b2, a2, 4'h1};
    cmd_valid = 1'b1; cmd_type = 1'b1; cmd_a = a1; cmd_b = b1; cmd_c = c1;
    step();
    cmd_a = a2; cmd_b = b2; cmd_c = c2;
    ones1 = 0; zeros = 0; ones2 = 0;
    for (int i = 0; i < 300; i++) begin
      if (operation !== w1) break;
      ones1++;
      step();
    end
    for (int i = 0; i < 20; i++) begin
      if (operation !== 32'd0) break;
      zeros++;
      step();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (operation !== w2) break;
      ones2++;
      step();
    end
    n_cmp++;
    if (ones1 !== MM_RUN_LEN || ones2 !== MM_RUN_LEN) begin
      n_err++; $display("FAIL b2b_len: got %0d/%0d expected %0d/%0d", ones1, ones2, MM_RUN_LEN, MM_RUN_LEN);
    end
    n_cmp++;
    if (zeros < 2) begin
      n_err++; $display("FAIL b2b_gap: got %0d zero cycles expected at least 2", zeros);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_idle: got busy=%b rdy=%b expected 0/1", busy, cmd_ready);
    end
  endtask

  task automatic test_enable();
    logic [31:0] w;
    int          ones;
    // Disabled in IDLE: command must not be taken
    enable = 1'b0; cmd_valid = 1'b1; cmd_type = 1'b1; cmd_a = 4'h3; cmd_b = 4'h4; cmd_c = 4'h5;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL en_idle_ready: got %b expected 0", cmd_ready);
    end
    repeat (3) step();
    n_cmp++;
    if (busy !== 1'b0 || operation !== 32'd0) begin
      n_err++; $display("FAIL en_idle_hold: got busy=%b op=%h expected 0/0", busy, operation);
    end
    enable = 1'b1;
    w = {16'h0000, 4'h5, 4'h4, 4'h3, 4'h1};
    step();
    cmd_valid = 1'b0;
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      if (operation === w) ones++;
      step();
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (operation !== w || busy !== 1'b1 || cmd_ready !== 1'b0 || data_ready !== 1'b0 || done !== 1'b0) begin
        n_err++; $display("FAIL en_freeze: got op=%h busy=%b rdy=%b drdy=%b done=%b expected %h/1/0/0/0",
                          operation, busy, cmd_ready, data_ready, done, w);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (operation !== w) break;
      ones++;
      step();
    end
    n_cmp++;
    if (ones !== MM_RUN_LEN) begin
      n_err++; $display("FAIL en_total: got %0d enabled opcode-1 cycles expected %0d", ones, MM_RUN_LEN);
    end
    n_cmp++;
    if (operation !== 32'd0 || done !== 1'b1) begin
      n_err++; $display("FAIL en_gap: got op=%h done=%b expected 0/1", operation, done);
    end
    step();
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_type = 1'b1; cmd_a = 4'h7; cmd_b = 4'h8; cmd_c = 4'h9;
    step();
    cmd_valid = 1'b0;
    repeat (10) step();
    n_cmp++;
    if (operation !== 32'h00009871) begin
      n_err++; $display("FAIL rm_running: got %h expected %h", operation, 32'h00009871);
    end
    reset = 1'b0;
    #1;
    exp_in = 32'd0;
    n_cmp++;
    if (operation !== 32'd0 || busy !== 1'b0 || cmd_ready !== 1'b0 || in_data !== exp_in) begin
      n_err++; $display("FAIL rm_async: got op=%h busy=%b rdy=%b in=%h expected 0/0/0/0", operation, busy, cmd_ready, in_data);
    end
    step();
    reset = 1'b1;
    step();
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || operation !== 32'd0) begin
      n_err++; $display("FAIL rm_release: got rdy=%b busy=%b op=%h expected 1/0/0", cmd_ready, busy, operation);
    end
    run_load(4'hA, 4'h1, 8'd2, 0, 32'hCAFE0000, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_load_basic();
    test_load_gapped();
    test_load_zero();
    test_load_random();
    test_matmul();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
